// File: rtl/mem_port_arbiter_if.sv
// Request/grant and shared-bus signals between the AES/SHA FSMs, the arbiter and the memory/SPI port.
// master = arbiter side; slave = requesters plus bus responder side.
interface mem_port_arbiter_if #(
  parameter int ADDRW = 24,
  parameter int LENW  = 4
);
  logic             req_aes;
  logic [ADDRW-1:0] addr_aes;
  logic             we_aes;
  logic [LENW-1:0]  len_aes;
  logic             gnt_aes;
  logic             done_aes;

  logic             req_sha;
  logic [ADDRW-1:0] addr_sha;
  logic             we_sha;
  logic [LENW-1:0]  len_sha;
  logic             gnt_sha;
  logic             done_sha;

  logic             bus_start;
  logic [ADDRW-1:0] bus_addr;
  logic             bus_we;
  logic [LENW-1:0]  bus_len;
  logic             bus_owner;
  logic             bus_ack;
  logic             busy;

  modport master (
    input  req_aes, addr_aes, we_aes, len_aes,
    output gnt_aes, done_aes,
    input  req_sha, addr_sha, we_sha, len_sha,
    output gnt_sha, done_sha,
    output bus_start, bus_addr, bus_we, bus_len, bus_owner, busy,
    input  bus_ack
  );

  modport slave (
    output req_aes, addr_aes, we_aes, len_aes,
    input  gnt_aes, done_aes,
    output req_sha, addr_sha, we_sha, len_sha,
    input  gnt_sha, done_sha,
    input  bus_start, bus_addr, bus_we, bus_len, bus_owner, busy,
    output bus_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared memory/SPI port for the AES and SHA FSMs; grant+bus_start one cycle after request,
// done one cycle after the last counted ack; a burst stalls indefinitely while bus_ack stays low.
module mem_port_arbiter #(
  parameter int ADDRW = 24,
  parameter int LENW  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OWN_AES = 1'b0;
  localparam logic OWN_SHA = 1'b1;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;

  logic             win_aes;
  logic             win_sha;
  logic             start;
  logic             done;
  logic             busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      owner_q <= OWN_AES;
      last_q  <= OWN_SHA;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    start   = 1'b0;
    done    = 1'b0;

    // On a tie the requester that did not own the previous burst wins.
    win_aes = bus_if.req_aes && (!bus_if.req_sha || (last_q == OWN_SHA));
    win_sha = bus_if.req_sha && !win_aes;

    unique case (state_q)
      IDLE: begin
        if (win_aes) begin
          addr_d  = bus_if.addr_aes;
          we_d    = bus_if.we_aes;
          len_d   = bus_if.len_aes;
          owner_d = OWN_AES;
          cnt_d   = '0;
          state_d = START;
        end else if (win_sha) begin
          addr_d  = bus_if.addr_sha;
          we_d    = bus_if.we_sha;
          len_d   = bus_if.len_sha;
          owner_d = OWN_SHA;
          cnt_d   = '0;
          state_d = START;
        end
      end

      START, BURST: begin
        start = (state_q == START);
        if (state_q == START) begin
          state_d = BURST;
        end
        // Compare before increment so len = all-ones runs 2^LENW beats without wrapping.
        if (bus_if.bus_ack) begin
          if (cnt_q == len_q) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + LENW'(1);
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        last_d  = owner_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy             = (state_q != IDLE);
  assign bus_if.busy      = busy;
  assign bus_if.gnt_aes   = busy && (owner_q == OWN_AES);
  assign bus_if.gnt_sha   = busy && (owner_q == OWN_SHA);
  assign bus_if.done_aes  = done && (owner_q == OWN_AES);
  assign bus_if.done_sha  = done && (owner_q == OWN_SHA);
  assign bus_if.bus_start = start;
  assign bus_if.bus_addr  = addr_q;
  assign bus_if.bus_we    = we_q;
  assign bus_if.bus_len   = len_q;
  assign bus_if.bus_owner = owner_q;

  a_gnt_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus_if.gnt_aes && bus_if.gnt_sha));
  a_done_with_gnt : assert property (@(posedge clk) disable iff (!rst_n)
    (!bus_if.done_aes || bus_if.gnt_aes) && (!bus_if.done_sha || bus_if.gnt_sha));

endmodule
